nibble_demux: RTL and testbench
===============================

NIBBLE_DEMUX -- requirements
Module: nibble_demux

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 The port clk SHALL be an input, 1 bit wide: the system clock, with all state updated on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide: the asynchronous, active-low reset.
REQ-004 The port data_in SHALL be an input, 1 bit wide: the serial bit, MSB first.
REQ-005 The port data_valid SHALL be an input, 1 bit wide: data_in is sampled this cycle.
REQ-006 The port start SHALL be an input, 1 bit wide: the qualified bit is slot 0 of a new frame.
REQ-007 The port select SHALL be an output, 2 bits wide: the slot index of the next data slot expected.
REQ-008 The port data_out SHALL be an output, 4 bits wide: the last completed nibble, held until the next completion.
REQ-009 The port out_valid SHALL be an output, 1 bit wide: a one-cycle pulse when data_out is updated.
REQ-010 The port busy SHALL be an output, 1 bit wide: high while a frame is in progress.
REQ-011 The port frame_err SHALL be an output, 1 bit wide: a one-cycle pulse on restart mid-frame.
REQ-012 The port parity_err SHALL be an output, 1 bit wide: a one-cycle pulse on parity failure (Configuration section).

Function
REQ-013 The slot-to-bit map SHALL be select 00->bit3, 01->bit2, 10->bit1, 11->bit0, the inverse of the team's 4:1 case mux, so that mux(select, demux output) reproduces the stream.
REQ-014 The state machine SHALL have the states IDLE, RECV and, with parity, PAR.
REQ-015 In IDLE, data_valid&start SHALL capture data_in into shadow bit3, set select=01 and go to RECV.
REQ-016 In IDLE, data_valid without start SHALL be ignored, with no state change and no error.
REQ-017 In RECV, data_valid&!start SHALL write data_in to shadow bit[3-select] and increment select.
REQ-018 In RECV, data_valid&start SHALL pulse frame_err, discard the partial nibble, capture data_in as bit3 and set select=01.
REQ-019 In RECV, a data_valid low cycle SHALL hold all state; no timeout applies.
REQ-020 Capturing slot 11 without parity SHALL be completion: on that same edge data_out<=shadow, out_valid=1 for one cycle, select<=00, and the state goes to IDLE.
REQ-021 Latency SHALL be 0 cycles after the last-bit sampling edge, i.e. data_out and out_valid are registered outputs from that edge.
REQ-022 Back-to-back frames SHALL be supported: a start in the cycle after completion SHALL be accepted with no gap.
REQ-023 The select counter SHALL wrap 11->00 only via completion and SHALL never exceed 11.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 data_out SHALL change only on completion, and partial frames SHALL never be visible on it.

Reset
REQ-026 Assertion of rst_n low SHALL, asynchronously, set the state to IDLE, select=00, the shadow to 0000, data_out=0000, and out_valid, busy, frame_err and parity_err to 0.
REQ-027 A reset asserted mid-frame SHALL discard the partial nibble with no error pulse.
REQ-028 The first frame after rst_n deassertion SHALL require start.

Configuration
REQ-029 When NIBBLE_PARITY_EN is defined, the frame SHALL be 5 qualified bits: 4 data bits followed by an even parity bit.
REQ-030 When NIBBLE_PARITY_EN is defined, capturing slot 11 SHALL go to PAR, with select held at 11 and busy high.
REQ-031 When NIBBLE_PARITY_EN is defined, in PAR, data_valid&!start SHALL check that XOR(shadow, data_in)==0.
REQ-032 When NIBBLE_PARITY_EN is defined and the parity check passes, the block SHALL perform completion per REQ-020.
REQ-033 When NIBBLE_PARITY_EN is defined and the parity check fails, the block SHALL pulse parity_err, leave data_out unchanged, keep out_valid low and go to IDLE.
REQ-034 When NIBBLE_PARITY_EN is defined, data_valid&start in PAR SHALL be handled as a restart per REQ-018.
REQ-035 When NIBBLE_PARITY_EN is not defined, the PAR state SHALL not exist, parity_err SHALL be tied to 0 and the frame SHALL be 4 bits.

Verification
REQ-036 The bench SHALL drive, with parity off, start+1 followed by 0,1,1 on consecutive valid cycles and SHALL check data_out=1011 with out_valid high for exactly 1 cycle.
REQ-037 The bench SHALL drive, with parity off, two back-to-back frames 1100 and 0011 and SHALL check two out_valid pulses 4 cycles apart with data_out 1100 then 0011.
REQ-038 The bench SHALL drive bits 1,0 (slots 0-1), then start+0, then 1,1,1, and SHALL check frame_err pulsing once and data_out=0111.
REQ-039 The bench SHALL drive frame 1010 with data_valid gaps of 3 cycles between bits and SHALL check that select steps 00->01->10->11->00 and data_out=1010.
REQ-040 The bench SHALL drive, with parity on, 0110 with parity 0 and check out_valid; then 0111 with parity 0 and check parity_err with data_out still 0110.
REQ-041 The bench SHALL assert rst_n low after 2 bits and SHALL check all outputs at reset values within the same cycle, then check that a fresh frame 1001 captures correctly.

Source files
------------

// File: rtl/nibble_demux.sv
// Serial-to-nibble demultiplexer: MSB-first bits are steered into slots 3..0 and published as one nibble.
// Optional even-parity fifth bit when NIBBLE_PARITY_EN is defined.
module nibble_demux (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  input  logic       data_valid,
  input  logic       start,
  output logic [1:0] select,
  output logic [3:0] data_out,
  output logic       out_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

`ifdef NIBBLE_PARITY_EN
  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

  state_t     state_q;
  logic [1:0] select_q;
  logic [3:0] shadow_q;
  logic [3:0] data_out_q;
  logic       out_valid_q;
  logic       frame_err_q;
  logic [1:0] slot_d;
  logic [3:0] shadow_d;

  // Slot 00 lands in bit3, slot 11 in bit0, so the 4:1 mux reproduces the stream.
  always_comb begin
    slot_d           = 2'd3 - select_q;
    shadow_d         = shadow_q;
    shadow_d[slot_d] = data_in;
  end

`ifdef NIBBLE_PARITY_EN
  logic parity_err_q;
  logic parity_ok_d;

  assign parity_ok_d = ~(^shadow_q ^ data_in);
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      select_q     <= 2'd0;
      shadow_q     <= 4'd0;
      data_out_q   <= 4'd0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef NIBBLE_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef NIBBLE_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (data_valid && start) begin
            shadow_q <= {data_in, 3'b000};
            select_q <= 2'd1;
            state_q  <= RECV;
          end
        end
        RECV: begin
          if (data_valid) begin
            if (start) begin
              frame_err_q <= 1'b1;
              shadow_q    <= {data_in, 3'b000};
              select_q    <= 2'd1;
            end else if (select_q == 2'd3) begin
              shadow_q <= shadow_d;
`ifdef NIBBLE_PARITY_EN
              state_q  <= PAR;
`else
              data_out_q  <= shadow_d;
              out_valid_q <= 1'b1;
              select_q    <= 2'd0;
              state_q     <= IDLE;
`endif
            end else begin
              shadow_q <= shadow_d;
              select_q <= select_q + 2'd1;
            end
          end
        end
`ifdef NIBBLE_PARITY_EN
        // Select stays at 11 while waiting for the parity bit.
        PAR: begin
          if (data_valid) begin
            if (start) begin
              frame_err_q <= 1'b1;
              shadow_q    <= {data_in, 3'b000};
              select_q    <= 2'd1;
              state_q     <= RECV;
            end else if (parity_ok_d) begin
              data_out_q  <= shadow_q;
              out_valid_q <= 1'b1;
              select_q    <= 2'd0;
              state_q     <= IDLE;
            end else begin
              parity_err_q <= 1'b1;
              select_q     <= 2'd0;
              state_q      <= IDLE;
            end
          end
        end
`endif
        default: begin
          state_q  <= IDLE;
          select_q <= 2'd0;
        end
      endcase
    end
  end

  assign select    = select_q;
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nibble_demux.sv
// Scoreboard bench for nibble_demux: expected nibbles are queued as frames are driven and
// popped by a negedge monitor whenever out_valid fires.
module tb_nibble_demux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dataIn = 1'b0;
  logic       dataValid = 1'b0;
  logic       startIn = 1'b0;
  logic [1:0] selectOut;
  logic [3:0] dataOut;
  logic       outValid;
  logic       busyOut;
  logic       frameErr;
  logic       parityErr;

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] expQ[$];
  int         pulseCycles[$];
  int         cycle = 0;
  int         frameErrCount = 0;
  int         parityErrCount = 0;
  logic [3:0] monExp;

`ifdef NIBBLE_PARITY_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  nibble_demux dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (dataIn),
    .data_valid (dataValid),
    .start      (startIn),
    .select     (selectOut),
    .data_out   (dataOut),
    .out_valid  (outValid),
    .busy       (busyOut),
    .frame_err  (frameErr),
    .parity_err (parityErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: every out_valid pulse must match the oldest queued nibble.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frameErr) frameErrCount++;
      if (parityErr) parityErrCount++;
      if (outValid) begin
        pulseCycles.push_back(cycle);
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_out_valid: data_out=%b, no nibble was expected", dataOut);
        end else begin
          monExp = expQ.pop_front();
          if (dataOut !== monExp) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_data_out: got %b, expected %b", dataOut, monExp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic s, input logic b);
    @(negedge clk);
    dataValid = 1'b1;
    startIn   = s;
    dataIn    = b;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dataValid = 1'b0;
      startIn   = 1'b0;
      dataIn    = 1'b0;
    end
  endtask

  task automatic sendParity(input logic [3:0] nib);
`ifdef NIBBLE_PARITY_EN
    applyStimulus(1'b0, ^nib);
`else
    if (nib === 4'bxxxx) idleCycles(0);
`endif
  endtask

  task automatic sendFrame(input logic [3:0] nib);
    expQ.push_back(nib);
    for (int i = 3; i >= 0; i--) applyStimulus(i == 3, nib[i]);
    sendParity(nib);
  endtask

  task automatic test_reset;
    #12;
    vectors++;
    if ({selectOut, dataOut, outValid, busyOut, frameErr, parityErr} !== 10'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got sel=%b dout=%b ov=%b busy=%b ferr=%b perr=%b, expected all zero",
               selectOut, dataOut, outValid, busyOut, frameErr, parityErr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    idleCycles(2);
    vectors++;
    if (busyOut !== 1'b0 || selectOut !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL no_start_ignored: got busy=%b sel=%b, expected busy=0 sel=00", busyOut, selectOut);
    end
  endtask

  task automatic test_basic;
    sendFrame(4'b1011);
    idleCycles(1);
    vectors++;
    if (outValid !== 1'b1 || dataOut !== 4'b1011) begin
      miscompares++;
      $display("[TB] FAIL basic_completion: got ov=%b dout=%b, expected ov=1 dout=1011", outValid, dataOut);
    end
    vectors++;
    if (busyOut !== 1'b0 || selectOut !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL basic_return_idle: got busy=%b sel=%b, expected busy=0 sel=00", busyOut, selectOut);
    end
    idleCycles(1);
    vectors++;
    if (outValid !== 1'b0 || dataOut !== 4'b1011) begin
      miscompares++;
      $display("[TB] FAIL basic_pulse_width: got ov=%b dout=%b, expected ov=0 dout=1011", outValid, dataOut);
    end
    idleCycles(2);
    vectors++;
    if (expQ.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL basic_queue: got %0d pending, expected 0", expQ.size());
    end
  endtask

  task automatic test_back_to_back;
    pulseCycles.delete();
    sendFrame(4'b1100);
    sendFrame(4'b0011);
    idleCycles(3);
    vectors++;
    if (pulseCycles.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_pulse_count: got %0d pulses, expected 2", pulseCycles.size());
    end else begin
      vectors++;
      if (pulseCycles[1] - pulseCycles[0] !== FRAME_LEN) begin
        miscompares++;
        $display("[TB] FAIL b2b_spacing: got %0d cycles, expected %0d", pulseCycles[1] - pulseCycles[0], FRAME_LEN);
      end
    end
    vectors++;
    if (expQ.size() !== 0 || dataOut !== 4'b0011) begin
      miscompares++;
      $display("[TB] FAIL b2b_final: got pending=%0d dout=%b, expected pending=0 dout=0011", expQ.size(), dataOut);
    end
  endtask

  task automatic test_restart;
    int errBefore;
    errBefore = frameErrCount;
    expQ.push_back(4'b0111);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    sendParity(4'b0111);
    idleCycles(3);
    vectors++;
    if (frameErrCount - errBefore !== 1) begin
      miscompares++;
      $display("[TB] FAIL restart_frame_err: got %0d pulses, expected 1", frameErrCount - errBefore);
    end
    vectors++;
    if (dataOut !== 4'b0111 || expQ.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL restart_data: got dout=%b pending=%0d, expected dout=0111 pending=0", dataOut, expQ.size());
    end
  endtask

  task automatic test_gaps;
    logic [3:0] nib;
    logic [1:0] expSel;
    nib = 4'b1010;
    expQ.push_back(nib);
    vectors++;
    if (selectOut !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL gap_select_start: got %b, expected 00", selectOut);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 0, nib[3 - i]);
      idleCycles(3);
`ifdef NIBBLE_PARITY_EN
      expSel = (i == 3) ? 2'd3 : 2'(i + 1);
`else
      expSel = (i == 3) ? 2'd0 : 2'(i + 1);
`endif
      vectors++;
      if (selectOut !== expSel) begin
        miscompares++;
        $display("[TB] FAIL gap_select_step%0d: got %b, expected %b", i, selectOut, expSel);
      end
    end
    sendParity(nib);
    idleCycles(2);
    vectors++;
    if (selectOut !== 2'b00 || dataOut !== 4'b1010 || expQ.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL gap_final: got sel=%b dout=%b pending=%0d, expected sel=00 dout=1010 pending=0",
               selectOut, dataOut, expQ.size());
    end
  endtask

  task automatic test_parity;
`ifdef NIBBLE_PARITY_EN
    int pErrBefore;
    sendFrame(4'b0110);
    idleCycles(2);
    vectors++;
    if (dataOut !== 4'b0110 || expQ.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL parity_good: got dout=%b pending=%0d, expected dout=0110 pending=0", dataOut, expQ.size());
    end
    pErrBefore = parityErrCount;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    idleCycles(1);
    vectors++;
    if (parityErr !== 1'b1 || outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL parity_bad_pulse: got perr=%b ov=%b, expected perr=1 ov=0", parityErr, outValid);
    end
    idleCycles(2);
    vectors++;
    if (parityErrCount - pErrBefore !== 1 || dataOut !== 4'b0110 || busyOut !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL parity_bad_hold: got perr_count=%0d dout=%b busy=%b, expected 1 0110 0",
               parityErrCount - pErrBefore, dataOut, busyOut);
    end
`else
    vectors++;
    if (parityErrCount !== 0 || parityErr !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL parity_tied_low: got count=%0d perr=%b, expected 0 0", parityErrCount, parityErr);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int errBefore;
    errBefore = frameErrCount;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({selectOut, dataOut, outValid, busyOut, frameErr, parityErr} !== 10'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got sel=%b dout=%b ov=%b busy=%b ferr=%b perr=%b, expected all zero",
               selectOut, dataOut, outValid, busyOut, frameErr, parityErr);
    end
    @(negedge clk);
    dataValid = 1'b0;
    startIn   = 1'b0;
    rst_n     = 1'b1;
    sendFrame(4'b1001);
    idleCycles(3);
    vectors++;
    if (dataOut !== 4'b1001 || expQ.size() !== 0 || frameErrCount !== errBefore) begin
      miscompares++;
      $display("[TB] FAIL midreset_fresh_frame: got dout=%b pending=%0d ferr_delta=%0d, expected 1001 0 0",
               dataOut, expQ.size(), frameErrCount - errBefore);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_restart();
    test_gaps();
    test_parity();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
